// File: rtl/vga_mode_ctrl.sv
// Key-driven pattern mode / brightness controller for the VGA pattern generator.
// Key presses edit a pending configuration that is committed only at frame_start.
module vga_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_MODES       = 8,
  parameter int unsigned BRIGHT_MAX      = 7,
  parameter logic        KEY_PRESSED_LVL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keyin,
  input  logic       frame_start,
  output logic [3:0] mode,
  output logic [2:0] bright,
  output logic       cfg_update,
  output logic       pending
);

  localparam int unsigned CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MODE_LAST   = 4'(NUM_MODES - 1);
  localparam logic [2:0] BRIGHT_TOP  = 3'(BRIGHT_MAX);
  localparam logic       RELEASED    = ~KEY_PRESSED_LVL;

  typedef enum logic {IDLE, ARMED} state_t;

  logic [3:0]    sync1, sync2, db;
  logic [CW-1:0] cnt [4];
  logic [3:0]    press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= {4{RELEASED}};
      sync2 <= {4{RELEASED}};
      db    <= {4{RELEASED}};
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= keyin;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press fires on the same cycle the debounced state flips toward "pressed".
  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      press[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST) && (sync2[i] == KEY_PRESSED_LVL);
  end

  state_t     state, state_n;
  logic [3:0] p_mode, p_mode_n, mode_n;
  logic [2:0] p_bright, p_bright_n, bright_n;
  logic       commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mode       <= '0;
      bright     <= BRIGHT_TOP;
      p_mode     <= '0;
      p_bright   <= BRIGHT_TOP;
      cfg_update <= 1'b0;
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      bright     <= bright_n;
      p_mode     <= p_mode_n;
      p_bright   <= p_bright_n;
      cfg_update <= commit;
    end
  end

  // Commit takes the pending set as it stood before any same-cycle event.
  always_comb begin
    commit     = (state == ARMED) && frame_start;
    mode_n     = commit ? p_mode : mode;
    bright_n   = commit ? p_bright : bright;
    p_mode_n   = p_mode;
    p_bright_n = p_bright;
    pending    = (state == ARMED);
    if (press[3]) begin
      p_mode_n   = '0;
      p_bright_n = BRIGHT_TOP;
    end else if (press[0]) begin
      p_mode_n = (p_mode == MODE_LAST) ? '0 : p_mode + 4'd1;
    end else if (press[1]) begin
      p_mode_n = (p_mode == '0) ? MODE_LAST : p_mode - 4'd1;
    end else if (press[2]) begin
      p_bright_n = (p_bright == BRIGHT_TOP) ? '0 : p_bright + 3'd1;
    end
    state_n = ((p_mode_n != mode_n) || (p_bright_n != bright_n)) ? ARMED : IDLE;
  end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl with a scoreboard of expected committed/pending state.
module tb_vga_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keyin;
  logic       frame_start;
  logic [3:0] mode;
  logic [2:0] bright;
  logic       cfg_update;
  logic       pending;

  vga_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .NUM_MODES(8),
    .BRIGHT_MAX(7),
    .KEY_PRESSED_LVL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keyin(keyin),
    .frame_start(frame_start),
    .mode(mode),
    .bright(bright),
    .cfg_update(cfg_update),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] mode;
    logic [2:0] bright;
    logic       pending;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   upd_cnt = 0;
  int   exp_upd = 0;
  int   cm, cb, pm, pb;

  always @(negedge clk) if (cfg_update === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    cm = 0; cb = 7; pm = 0; pb = 7;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag     = tag;
    e.mode    = 4'(cm);
    e.bright  = 3'(cb);
    e.pending = (pm != cm) || (pb != cb);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_mode"}, 8'(mode), 8'(e.mode));
    chk({e.tag, "_bright"}, 8'(bright), 8'(e.bright));
    chk({e.tag, "_pending"}, 8'(pending), 8'(e.pending));
  endtask

  task automatic model_press(input logic [3:0] m);
    if (m[3]) begin pm = 0; pb = 7; end
    else if (m[0]) pm = (pm == 7) ? 0 : pm + 1;
    else if (m[1]) pm = (pm == 0) ? 7 : pm - 1;
    else if (m[2]) pb = (pb == 7) ? 0 : pb + 1;
  endtask

  // mask bit set = key held down for 10 cycles, then released and settled.
  task automatic press(input logic [3:0] m);
    keyin = ~m;
    repeat (10) @(negedge clk);
    keyin = 4'hF;
    repeat (10) @(negedge clk);
    model_press(m);
  endtask

  task automatic frame(input string tag);
    logic do_commit;
    do_commit = (pm != cm) || (pb != cb);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    if (do_commit) begin cm = pm; cb = pb; exp_upd++; end
    chk({tag, "_upd"}, 8'(cfg_update), 8'(do_commit));
    push_exp(tag);
    pop_check();
    @(negedge clk);
    chk({tag, "_upd_end"}, 8'(cfg_update), 8'd0);
    chk({tag, "_upd_cnt"}, 8'(upd_cnt), 8'(exp_upd));
  endtask

  initial begin
    rst = 1'b0; keyin = 4'hF; frame_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    push_exp("in_reset"); pop_check();
    chk("in_reset_upd", 8'(cfg_update), 8'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    push_exp("after_reset"); pop_check();
    frame("idle_frame");

    // key0: pending rises exactly 6 cycles after the raw press
    keyin[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("k0_pend_early", 8'(pending), 8'd0);
    @(negedge clk);
    chk("k0_pend_rise", 8'(pending), 8'd1);
    repeat (4) @(negedge clk);
    keyin = 4'hF;
    repeat (10) @(negedge clk);
    model_press(4'b0001);
    push_exp("k0_held"); pop_check();
    frame("k0_frame");

    // bounce shorter than the debounce window
    for (int i = 0; i < 6; i++) begin
      keyin[0] = ~keyin[0];
      repeat (2) @(negedge clk);
    end
    keyin = 4'hF;
    repeat (10) @(negedge clk);
    push_exp("bounce"); pop_check();
    frame("bounce_frame");

    press(4'b1000);
    frame("restore_frame");
    press(4'b0010);
    frame("k1_wrap_frame");
    press(4'b0100);
    frame("k2_wrap_frame");

    press(4'b0001);
    push_exp("cancel_armed"); pop_check();
    press(4'b0010);
    push_exp("cancel_idle"); pop_check();
    frame("cancel_frame");

    for (int i = 0; i < 4; i++) press(4'b0001);
    press(4'b0100);
    press(4'b0100);
    frame("m3b2_frame");
    press(4'b1001);
    push_exp("prio_pend"); pop_check();
    frame("prio_frame");

    press(4'b0001);
    push_exp("pre_rst"); pop_check();
    #1 rst = 1'b0;
    #1;
    model_reset();
    push_exp("async_rst"); pop_check();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    frame("post_rst_frame");

    // event coinciding with frame_start: commit old pending, then apply event
    press(4'b0001);
    keyin[2] = 1'b0;
    repeat (5) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cm = pm; cb = pb; exp_upd++;
    model_press(4'b0100);
    chk("coinc_upd", 8'(cfg_update), 8'd1);
    push_exp("coinc"); pop_check();
    repeat (4) @(negedge clk);
    keyin = 4'hF;
    repeat (10) @(negedge clk);
    frame("coinc_frame2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
